ps2_kbd_rx: RTL and testbench

- PS/2 keyboard receiver with an 8-entry scan-code FIFO.
- Sits upstream of the hex-display path; each buffered byte is split by the consumer into two nibbles that drive one 7-segment decoder each.
- Deserialises the 11-bit PS/2 frame sampled on the synchronised keyboard clock.
- Checks framing, parity and inter-bit timeout; presents bytes with a ready/read-strobe handshake.

---
 rtl/ps2_kbd_rx.sv | 151 +++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame receiver with scan-code FIFO
//
// Ports:
//   clk        system clock, rising edge
//   clrn       asynchronous active-low reset
//   ps2_clk    raw keyboard clock (asynchronous)
//   ps2_data   raw keyboard data (asynchronous)
//   nextdata_n active-low read strobe, pops the head byte when ready=1
//   data       FIFO head byte (oldest unread scan code)
//   ready      FIFO non-empty
//   overflow   sticky, a valid frame was dropped because the FIFO was full
//   frame_err  one-cycle pulse on bad start/stop/parity or inter-bit timeout

module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [1:0]             dat_sync;
  logic                   fall;
  logic                   sample;
  logic [3:0]             cnt_q, cnt_d;
  logic [9:0]             buf_q;
  logic [TW-1:0]          tmo_q;
  logic [PW:0]            w_ptr, r_ptr;
  logic [7:0]             fifo [FIFO_DEPTH];
  logic                   capture, evaluate, timeout;
  logic                   frame_ok, empty, full, push, pop, drop;

  // clk_sync[0] is the newest stage; a fall is the oldest pair reading 1 then 0
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= '0;
      dat_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign sample = dat_sync[1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    evaluate = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          capture = 1'b1;
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          if (cnt_q == 4'd10) begin
            // stop bit is the live sample, never stored
            evaluate = 1'b1;
            cnt_d    = 4'd0;
            state_d  = IDLE;
          end else begin
            capture = 1'b1;
            cnt_d   = cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      buf_q <= '0;
      tmo_q <= '0;
    end else begin
      if (capture) buf_q[cnt_q] <= sample;
      if (state_q == SHIFT && !fall) tmo_q <= tmo_q + TW'(1);
      else                           tmo_q <= '0;
    end
  end

  assign frame_ok = ~buf_q[0] & sample & (^buf_q[9:1]);
  assign empty    = (w_ptr == r_ptr);
  assign full     = (w_ptr[PW-1:0] == r_ptr[PW-1:0]) && (w_ptr[PW] != r_ptr[PW]);
  // fullness uses pre-pop pointers, so a same-cycle pop does not rescue a full FIFO
  assign push     = evaluate & frame_ok & ~full;
  assign drop     = evaluate & frame_ok & full;
  assign pop      = ~nextdata_n & ~empty;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= 8'h00;
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) begin
        fifo[w_ptr[PW-1:0]] <= buf_q[8:1];
        w_ptr <= w_ptr + (PW+1)'(1);
      end
      if (pop)  r_ptr    <= r_ptr + (PW+1)'(1);
      if (drop) overflow <= 1'b1;
      frame_err <= (evaluate & ~frame_ok) | timeout;
    end
  end

  assign data  = fifo[r_ptr[PW-1:0]];
  assign ready = ~empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed scoreboard bench for ps2_kbd_rx

module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int wide_cnt = 0;
  logic prev_err = 1'b0;
  logic exp_ovf = 1'b0;
  logic [7:0] sb[$];

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (frame_err && prev_err) wide_cnt++;
    prev_err = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (7) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic bad_par);
    if (!bad_par) begin
      if (sb.size() < DEPTH) sb.push_back(b);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bits(mk(b, bad_par), 11);
    model_frame(b, bad_par);
    repeat (8) @(negedge clk);
  endtask

  // drives the stop bit and drops ps2_clk, returning at that negedge
  task automatic stop_bit_fall();
    @(negedge clk) ps2_data = 1'b1;
    repeat (7) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic stop_bit_rise();
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    check({tag, "_ready"}, ready, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_data"}, data, exp);
    end
    nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  initial begin : main
    int e0;
    logic [7:0] exp;

    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_ready", ready, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    clrn = 1'b1;
    repeat (4) @(negedge clk);

    // 0x1C with latency check on the 11th edge
    e0 = err_cnt;
    send_bits(mk(8'h1C, 1'b0), 10);
    stop_bit_fall();
    @(posedge clk); @(posedge clk); #1;
    check("1c_ready_before", ready, 0);
    @(posedge clk); #1;
    check("1c_ready_after", ready, 1);
    model_frame(8'h1C, 1'b0);
    stop_bit_rise();
    pop_check("1c_pop");
    check("1c_empty", ready, 0);
    check("1c_no_err", err_cnt - e0, 0);

    // parity error
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    check("par_err_pulse", err_cnt - e0, 1);
    check("par_ready", ready, 0);

    // fill and overflow
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0);
    check("fill_ready", ready, 1);
    check("fill_ovf", overflow, 0);
    send_frame(8'h09, 1'b0);
    check("ovf_set", overflow, exp_ovf);
    for (int i = 0; i < 8; i++) pop_check("drain");
    @(negedge clk);
    check("drain_empty", ready, 0);
    check("ovf_sticky", overflow, 1);
    nextdata_n = 1'b0;
    repeat (3) @(negedge clk);
    nextdata_n = 1'b1;
    check("pop_empty_ignored", ready, 0);

    // inter-bit timeout
    e0 = err_cnt;
    send_bits(mk(8'hAA, 1'b0), 5);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_pulse", err_cnt - e0, 1);
    check("tmo_ready", ready, 0);
    send_frame(8'hF0, 1'b0);
    pop_check("f0_pop");

    // reset mid-frame
    e0 = err_cnt;
    send_bits(mk(8'h77, 1'b0), 4);
    @(negedge clk) clrn = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_data", data, 8'h00);
    check("mrst_ready", ready, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_err", frame_err, 0);
    clrn = 1'b1;
    exp_ovf = 1'b0;
    sb.delete();
    repeat (4) @(negedge clk);
    check("mrst_no_pulse", err_cnt - e0, 0);
    send_frame(8'h45, 1'b0);
    pop_check("45_pop");
    check("45_empty", ready, 0);

    // simultaneous push and pop with three bytes buffered
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33, 1'b0);
    send_bits(mk(8'h2B, 1'b0), 10);
    stop_bit_fall();
    @(posedge clk); @(posedge clk); #1;
    exp = sb.pop_front();
    check("sim_head", data, exp);
    nextdata_n = 1'b0;
    model_frame(8'h2B, 1'b0);
    @(posedge clk); #1;
    nextdata_n = 1'b1;
    stop_bit_rise();
    for (int i = 0; i < 3; i++) pop_check("sim_pop");
    @(negedge clk);
    check("sim_empty", ready, 0);
    check("final_ovf", overflow, exp_ovf);
    check("err_width", wide_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
